// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter for the single-port data memory
// Winner is picked combinationally each cycle; done/rdata return one cycle after the grant.
module dmem_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          m0_done_q, m0_done_d;
  logic          m1_done_q, m1_done_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic win_valid;
  logic win;
  logic win_lock;
  logic other_req;
  logic same_owner;

  always_comb begin
    win_valid = 1'b0;
    win       = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        win_valid = 1'b1;
        // a locked owner keeps the bus until its hold budget runs out
        if (state_q == OWN0 && m0_lock && hold_q < HOLD_MAX) begin
          win = 1'b0;
        end else if (state_q == OWN1 && m1_lock && hold_q < HOLD_MAX) begin
          win = 1'b1;
        end else begin
          win = ~last_q;
        end
      end else if (m0_req) begin
        win_valid = 1'b1;
        win       = 1'b0;
      end else if (m1_req) begin
        win_valid = 1'b1;
        win       = 1'b1;
      end
    end

    m0_gnt    = win_valid && !win;
    m1_gnt    = win_valid && win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end

    win_lock   = win ? m1_lock : m0_lock;
    other_req  = win ? m0_req : m1_req;
    same_owner = (state_q == OWN1 && win) || (state_q == OWN0 && !win);

    state_d = !win_valid ? IDLE : (win ? OWN1 : OWN0);
    last_d  = win_valid ? win : last_q;

    hold_d = '0;
    if (win_valid && same_owner && other_req && win_lock) begin
      hold_d = (hold_q < HOLD_MAX) ? hold_q + HW'(1) : HOLD_MAX;
    end

    m0_done_d  = m0_gnt;
    m1_done_d  = m1_gnt;
    m0_rdata_d = (m0_gnt && !m0_we) ? mem_rdata : m0_rdata_q;
    m1_rdata_d = (m1_gnt && !m1_we) ? mem_rdata : m1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_q     <= '0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter
// Drives one vector per cycle and checks grants, memory drive and return path mid-cycle.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_done, m1_gnt, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // single-port memory with combinational read
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic          rst;
    logic          r0, w0, l0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1, l1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic          dn0, dn1;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic rst_i,
    input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic g0, input logic g1, input logic mwe, input logic [AW-1:0] maddr, input logic [DW-1:0] mwd,
    input logic dn0, input logic dn1, input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    vec_t v;
    v.rst = rst_i;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd;
    v.dn0 = dn0; v.dn1 = dn1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // entered at posedge+1; drives, checks at the falling edge, returns at next posedge+1
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_lock = v.l0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_lock = v.l1; m1_addr = v.a1; m1_wdata = v.d1;
    #4;
    chk({tag, " m0_gnt"},    32'(m0_gnt),    32'(v.g0));
    chk({tag, " m1_gnt"},    32'(m1_gnt),    32'(v.g1));
    chk({tag, " mem_we"},    32'(mem_we),    32'(v.mwe));
    chk({tag, " mem_addr"},  32'(mem_addr),  32'(v.maddr));
    chk({tag, " mem_wdata"}, mem_wdata,      v.mwd);
    chk({tag, " m0_done"},   32'(m0_done),   32'(v.dn0));
    chk({tag, " m1_done"},   32'(m1_done),   32'(v.dn1));
    chk({tag, " m0_rdata"},  m0_rdata,       v.rd0);
    chk({tag, " m1_rdata"},  m1_rdata,       v.rd1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] DB = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] A1 = 32'hA000_0001;
  localparam logic [DW-1:0] A2 = 32'hA000_0002;

  vec_t tbl [$];
  vec_t v;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[5] = DB;

    // reset, lone m0 read, tie after reset with write-then-read, alternating round robin
    tbl.push_back(mk(1, 1,0,0,7'd5,0,      0,0,0,7'd0,0, 0,0,0,7'd0,0,       0,0, 0,0));
    tbl.push_back(mk(0, 1,0,0,7'd5,0,      0,0,0,7'd0,0, 1,0,0,7'd5,0,       0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0,7'd0,0,      0,0,0,7'd0,0, 0,0,0,7'd0,0,       1,0, DB,0));
    tbl.push_back(mk(1, 0,0,0,7'd0,0,      0,0,0,7'd0,0, 0,0,0,7'd0,0,       0,0, DB,0));
    tbl.push_back(mk(0, 1,1,0,7'd3,32'h11, 1,0,0,7'd3,0, 1,0,1,7'd3,32'h11,  0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0,7'd0,0,      1,0,0,7'd3,0, 0,1,0,7'd3,0,       1,0, 0,0));
    tbl.push_back(mk(0, 0,0,0,7'd0,0,      0,0,0,7'd0,0, 0,0,0,7'd0,0,       0,1, 0,32'h11));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(0, 1,0,0,7'd1,0, 1,0,0,7'd2,0,
                       (i % 2 == 0), (i % 2 == 1), 0, (i % 2 == 0) ? 7'd1 : 7'd2, 0,
                       (i % 2 == 1), (i > 0 && i % 2 == 0),
                       (i >= 1) ? A1 : 32'h0, (i >= 2) ? A2 : 32'h11));
    end
    tbl.push_back(mk(0, 0,0,0,7'd0,0, 0,0,0,7'd0,0, 0,0,0,7'd0,0, 0,1, A1,A2));

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // m1 locked burst: four grants, then m0, then m1 again
    apply(mk(0, 1,0,0,7'd1,0, 0,0,0,7'd0,0, 1,0,0,7'd1,0, 0,0, A1,A2), "lock_pre");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 1,0, A1,A2), "lock_1");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 0,1, A1,A2), "lock_2");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 0,1, A1,A2), "lock_3");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 0,1, A1,A2), "lock_4");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 1,0,0,7'd1,0, 0,1, A1,A2), "lock_m0");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 1,0, A1,A2), "lock_m1");

    // m0 waits out a burst, then withdraws just before its turn
    apply(mk(0, 1,0,0,7'd1,0, 0,0,0,7'd0,0, 1,0,0,7'd1,0, 0,1, A1,A2), "drop_pre");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 1,0, A1,A2), "drop_1");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 0,1, A1,A2), "drop_2");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 0,1, A1,A2), "drop_3");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,1,7'd2,0, 0,1,0,7'd2,0, 0,1, A1,A2), "drop_4");
    apply(mk(0, 0,0,0,7'd0,0, 0,0,0,7'd0,0, 0,0,0,7'd0,0, 0,1, A1,A2), "drop_gone");
    apply(mk(0, 0,0,0,7'd0,0, 0,0,0,7'd0,0, 0,0,0,7'd0,0, 0,0, A1,A2), "drop_nodone");

    // reset coincides with an m1 write request
    apply(mk(1, 0,0,0,7'd0,0, 1,1,0,7'd9,32'h99, 0,0,0,7'd0,0, 0,0, A1,A2), "rst_wr");
    apply(mk(0, 0,0,0,7'd0,0, 0,0,0,7'd0,0,      0,0,0,7'd0,0, 0,0, 0,0),   "rst_after");
    apply(mk(0, 1,0,0,7'd1,0, 1,0,0,7'd2,0,      1,0,0,7'd1,0, 0,0, 0,0),   "rst_tie");
    apply(mk(0, 0,0,0,7'd0,0, 0,0,0,7'd0,0,      0,0,0,7'd0,0, 1,0, A1,0),  "rst_done");
    v.d0 = mem[9];
    chk("rst_nowrite mem9", v.d0, 32'hA000_0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter that shares the single-port data memory between the rv32i core load/store port (m0) and a second requester (m1), such as a program loader or DMA engine.
- One access per cycle.
- Round-robin fairness, with an optional bounded lock for back-to-back bursts.
- Registered read-data return to the master that issued the read.
- Sits between the core/loader and data_mem; the core stalls on m0_gnt.

Parameters:
AW, 7, memory word-address width (matches data_mem daddr)
DW, 32, data width
MAX_HOLD, 4, max consecutive grants a locked master keeps while the other master is requesting (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  core access request; held until m0_gnt
m0_we  in  1  core write enable (1 = store)
m0_lock  in  1  core requests keeping the bus for its next access
m0_addr  in  AW  core address
m0_wdata  in  DW  core store data
m0_gnt  out  1  core access accepted this cycle
m0_done  out  1  one-cycle pulse, cycle after m0 grant
m0_rdata  out  DW  core load data, valid when m0_done follows a read
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same as m0, for master 1
mem_we  out  1  to data_mem d_we
mem_addr  out  AW  to data_mem daddr
mem_wdata  out  DW  to data_mem dwdata
mem_rdata  in  DW  from data_mem drdata (combinational read)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - m0/m1_done = 0; m0/m1_rdata = 0.
  - State = IDLE; last_grant = 1, so m0 wins the first tie; hold_cnt = 0.
  - Combinational outputs are 0 while rst = 1: gnt, mem_we, mem_addr, mem_wdata.
- State (registered owner of the previous cycle's grant):
  - IDLE: no grant last cycle.
  - OWN0: m0 was granted last cycle.
  - OWN1: m1 was granted last cycle.
- Winner selection (combinational, every cycle):
  - Neither req: no winner; next state IDLE.
  - Exactly one req: that master wins.
  - Both req, state OWNx, mx_lock = 1, and hold_cnt < MAX_HOLD-1: master x wins again.
  - Both req otherwise: the master != last_grant wins.
- Grant: mX_gnt = 1 only for the winner, in the same cycle. At most one gnt is high in any cycle.
- Memory drive:
  - mem_addr and mem_wdata = winner's fields.
  - mem_we = winner_we & gnt.
  - No winner: mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - mem_we is never high without a gnt.
- Return path:
  - On the edge after a grant, the winner's done = 1 for exactly one cycle.
  - If the access was a read, mX_rdata <= mem_rdata sampled in the grant cycle.
  - Writes do not change rdata.
  - The non-winner's rdata holds its value.
- Latency: a request is granted in its first cycle if uncontested; done arrives 1 cycle after gnt. A master can be granted every cycle (full throughput).
- hold_cnt:
  - Increments when the same master is granted in consecutive cycles while the other master is requesting.
  - Resets to 0 when the grant switches, when no grant occurs, or when the owner's lock = 0.
  - Saturates at MAX_HOLD-1.
- last_grant updates to the winner on every grant; it is unchanged on idle cycles.
- Request rules:
  - A master must hold req, we, addr and wdata stable until gnt.
  - Dropping req before gnt is legal and produces no access.
  - A lock asserted without req is ignored.
- Starvation bound: a requesting master waits at most MAX_HOLD cycles.
- Reset mid-operation: a grant issued in the cycle rst is sampled produces no done; all state returns to reset values.

Test Plan:
1. Reset, then m0 read addr 0x05 alone (mem holds 0xDEADBEEF at 0x05) -> m0_gnt = 1 in cycle 0, mem_we = 0, mem_addr = 0x05; cycle 1: m0_done = 1, m0_rdata = 0xDEADBEEF; m1 signals stay 0.
2. Both masters request in the first cycle after reset (m0 write 0x11 -> addr 3, m1 read addr 3), no lock -> cycle 0: m0 granted and writes; cycle 1: m1 granted; cycle 2: m1_done with m1_rdata = 0x11.
3. Both masters request continuously, no lock -> grants alternate m0, m1, m0, m1 for 8 cycles; never two gnts in the same cycle.
4. m1_lock = 1 and both request continuously with MAX_HOLD = 4, m1 granted first -> m1 granted 4 consecutive cycles, then m0 granted, then m1 again.
5. m0 holds req until m1's burst ends; m0 drops req one cycle before it would be granted -> no m0 gnt, no mem access, and no m0_done pulse.
6. Assert rst in the same cycle as an m1 write grant -> no m1_done in the following cycle; all outputs 0; the next tie goes to m0.
